// File: rtl/vga_textram_if.sv
// Pipelined Wishbone bus between the video fetch master / CPU and the text RAM.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        ack;
    logic        stall;
`ifdef NO_MODPORT_EXPRESSIONS
    logic [31:0] dat_m;
    logic [31:0] dat_s;

    modport master (output cyc, stb, we, adr, sel, dat_m, input dat_s, ack, stall);
    modport slave  (input cyc, stb, we, adr, sel, dat_m, output dat_s, ack, stall);
`else
    logic [31:0] dat_i;
    logic [31:0] dat_o;

    modport master (output cyc, stb, we, adr, sel, dat_i, input dat_o, ack, stall);
    modport slave  (input cyc, stb, we, adr, sel, dat_i, output dat_o, ack, stall);
`endif
endinterface

// File: rtl/vga_textram.sv
// Text-mode character RAM: clears itself to FILL after reset, then serves
// byte-enabled Wishbone reads/writes with a fixed two-cycle ack latency.
module vga_textram #(
    parameter int unsigned DEPTH = 2400,
    parameter int unsigned AW    = 12,
    parameter logic [31:0] FILL  = 32'h00070020
) (
    input  logic clk_i,
    input  logic rst_i,
    if_wb.slave  bus
);

    localparam logic [0:0]    ST_CLEAR = 1'b0;
    localparam logic [0:0]    ST_RUN   = 1'b1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_X  = (AW + 1)'(DEPTH);

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          v1_q, rd1_q, oob1_q;
    logic          v2_q;
    logic          stall_q;
    logic [31:0]   dat_q;

    logic [AW-1:0] idx;
    logic          in_range;
    logic          accept;
    logic [31:0]   wdat;

    logic          ram_en;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdat;
    logic [31:0]   ram_rd_q;
    logic [31:0]   mem [DEPTH];

    logic          unused_adr;

`ifdef NO_MODPORT_EXPRESSIONS
    assign wdat      = bus.dat_m;
    assign bus.dat_s = dat_q;
`else
    assign wdat      = bus.dat_i;
    assign bus.dat_o = dat_q;
`endif

    assign bus.ack    = v2_q;
    assign bus.stall  = stall_q;
    assign unused_adr = ^{bus.adr[31:AW+2], bus.adr[1:0]};

    assign idx      = bus.adr[AW+1:2];
    assign in_range = {1'b0, idx} < DEPTH_X;
    assign accept   = (state_q == ST_RUN) && bus.cyc && bus.stb && !stall_q;

    // Next state and RAM port steering: the clear counter owns the port in CLEAR.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_be   = 4'h0;
        ram_addr = idx;
        ram_wdat = wdat;
        case (state_q)
            ST_CLEAR: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_be   = 4'hF;
                ram_addr = cnt_q;
                ram_wdat = FILL;
                cnt_d    = cnt_q + AW'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (accept && in_range) begin
                    ram_en = 1'b1;
                    ram_we = bus.we;
                    ram_be = bus.we ? bus.sel : 4'h0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Single-port RAM with byte enables and registered read data.
    always_ff @(posedge clk_i) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_we && ram_be[i]) begin
                    mem[ram_addr][8*i +: 8] <= ram_wdat[8*i +: 8];
                end
            end
            ram_rd_q <= mem[ram_addr];
        end
    end

    // Control state and response pipeline; dropping cyc flushes in-flight acks.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            v1_q    <= 1'b0;
            rd1_q   <= 1'b0;
            oob1_q  <= 1'b0;
            v2_q    <= 1'b0;
            stall_q <= 1'b1;
            dat_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= (state_d == ST_CLEAR);
            v1_q    <= accept;
            rd1_q   <= !bus.we;
            oob1_q  <= !in_range;
            v2_q    <= v1_q && bus.cyc;
            if (v1_q && bus.cyc && rd1_q) begin
                dat_q <= oob1_q ? 32'h0 : ram_rd_q;
            end
        end
    end

endmodule

// File: tb/tb_vga_textram.sv
// Scoreboard bench for vga_textram: requests push expected acks, a monitor pops them.
module tb_vga_textram;

    localparam int unsigned DEPTH = 2400;
    localparam int unsigned AW    = 12;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    if_wb bus();

    vga_textram #(.DEPTH(DEPTH), .AW(AW), .FILL(32'h00070020)) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .bus  (bus)
    );

    typedef struct packed {
        logic        is_rd;
        logic [31:0] dat;
        logic [31:0] cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] cycle_cnt = 32'd0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 32'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Every ack must match the oldest outstanding request: cycle and read data.
    always @(negedge clk) begin
        if (rst_i === 1'b1 && bus.ack === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack cycle=%0d dat_o=%h", cycle_cnt, bus.dat_o);
            end else begin
                mon_e = q.pop_front();
                if (cycle_cnt != mon_e.cyc || (mon_e.is_rd && bus.dat_o !== mon_e.dat)) begin
                    bad++;
                    $display("FAIL ack_check cycle actual=%0d required=%0d dat_o actual=%h required=%h",
                             cycle_cnt, mon_e.cyc, bus.dat_o, mon_e.dat);
                end
            end
        end
    end

    task automatic push_exp(input logic is_rd, input logic [31:0] expv);
        exp_t e;
        e.is_rd = is_rd;
        e.dat   = expv;
        e.cyc   = cycle_cnt + 32'd2;
        q.push_back(e);
    endtask

    task automatic req(input logic we, input logic [31:0] idx, input logic [3:0] sel,
                       input logic [31:0] d, input logic push, input logic [31:0] expv);
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = we;
        bus.adr   = idx << 2;
        bus.sel   = sel;
        bus.dat_i = d;
        if (push) push_exp(!we, expv);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bus.stb = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending actual=%0d required=0", q.size());
            q.delete();
        end
        bus.cyc = 1'b0;
        @(posedge clk); #1;
    endtask

    // Called right after reset release with a read of idx already driven.
    task automatic clear_check(input logic [31:0] idx, input logic [31:0] expv);
        int   n    = 0;
        int   ackc = 0;
        logic done = 1'b0;
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.we  = 1'b0;
        bus.adr = idx << 2;
        while (!done) begin
            @(negedge clk);
            if (bus.stall) begin
                n++;
                if (bus.ack) ackc++;
                if (n > DEPTH + 8) done = 1'b1;
            end else begin
                done = 1'b1;
            end
        end
        check("clear_stall_cycles", 32'(n), DEPTH);
        check("clear_no_ack", 32'(ackc), 32'd0);
        if (!bus.stall) push_exp(1'b1, expv);
        @(posedge clk); #1;
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycle actual=%0d required=finished", cycle_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int ackc;
        rst_i     = 1'b0;
        bus.cyc   = 1'b0;
        bus.stb   = 1'b0;
        bus.we    = 1'b0;
        bus.adr   = 32'h0;
        bus.sel   = 4'h0;
        bus.dat_i = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 32'(bus.stall), 32'd1);
        check("reset_ack", 32'(bus.ack), 32'd0);
        check("reset_dat_o", bus.dat_o, 32'h0);

        // Release reset while holding a read of index 5.
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.adr = 32'd5 << 2;
        @(posedge clk); #1;
        rst_i = 1'b1;
        clear_check(32'd5, 32'h00070020);

        // Partial byte write: lanes 0 and 2 take new data, lanes 1 and 3 keep FILL.
        req(1'b1, 32'd10, 4'b0101, 32'hAABBCCDD, 1'b1, 32'h0);
        req(1'b0, 32'd10, 4'b0000, 32'h0, 1'b1, 32'h00BB00DD);
        drain();

        // Back-to-back writes then eight back-to-back reads.
        for (int i = 0; i < 8; i++) req(1'b1, 32'(i), 4'hF, 32'(i * 3), 1'b1, 32'h0);
        for (int i = 0; i < 8; i++) req(1'b0, 32'(i), 4'hF, 32'h0, 1'b1, 32'(i * 3));
        drain();

        // Read immediately after write to the same index.
        req(1'b1, 32'd20, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0);
        req(1'b0, 32'd20, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF);
        drain();

        // Out-of-range index: acked, reads 0, no aliasing into valid cells.
        req(1'b1, DEPTH, 4'hF, 32'h12345678, 1'b1, 32'h0);
        req(1'b0, DEPTH, 4'hF, 32'h0, 1'b1, 32'h0);
        req(1'b0, 32'd0, 4'hF, 32'h0, 1'b1, 32'h0);
        req(1'b0, DEPTH - 1, 4'hF, 32'h0, 1'b1, 32'h00070020);
        drain();

        // Two reads, then cyc drops; the first read's ack is already in v2 in
        // that cycle, the second must never appear.
        req(1'b0, 32'd3, 4'hF, 32'h0, 1'b1, 32'd9);
        req(1'b0, 32'd4, 4'hF, 32'h0, 1'b0, 32'h0);
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        @(negedge clk);
        ackc = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.ack) ackc++;
        end
        check("cyc_drop_no_ack", 32'(ackc), 32'd0);
        check("cyc_drop_queue_empty", 32'(q.size()), 32'd0);
        q.delete();

        // Reset in the middle of a burst drops the pending ack and re-clears.
        req(1'b0, 32'd1, 4'hF, 32'h0, 1'b0, 32'h0);
        rst_i   = 1'b0;
        bus.adr = 32'd2 << 2;
        @(posedge clk);
        @(negedge clk);
        check("reset_burst_ack", 32'(bus.ack), 32'd0);
        check("reset_burst_dat_o", bus.dat_o, 32'h0);
        @(posedge clk); #1;
        rst_i = 1'b1;
        clear_check(32'd20, 32'h00070020);

        check("final_queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
